// File: rtl/lab4_if.sv
// Operand/flag bundle for the lab4 magnitude comparator.
interface lab4_if #(
  parameter int unsigned WIDTH = 2
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             green;
  logic             red;
  logic             blue;
  logic             valid;

  modport master (
    output en, a, b,
    input  green, red, blue, valid
  );

  modport slave (
    input  en, a, b,
    output green, red, blue, valid
  );
endinterface

// File: rtl/lab4.sv
// Registered unsigned comparator: one-hot green (a>b), red (a<b), blue (a==b),
// captured on enabled edges, with a sticky valid flag.
module lab4 #(
  parameter int unsigned WIDTH = 2
) (
  input logic   clk,
  input logic   rst_n,
  lab4_if.slave bus
);

  typedef enum logic {
    ST_EMPTY,
    ST_HELD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rst_pipe;
  logic             run;
  logic             capture;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             green_q;
  logic             red_q;
  logic             blue_q;
  logic             valid_q;

  assign a_in = bus.a;
  assign b_in = bus.b;

  // Assertion is immediate via rst_n; release ripples through two flops so
  // no capture can happen on the first edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign run = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (run && bus.en) begin
          capture   = 1'b1;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (run && bus.en) begin
          capture = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      green_q <= 1'b0;
      red_q   <= 1'b0;
      blue_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (capture) begin
      green_q <= (a_in > b_in);
      red_q   <= (a_in < b_in);
      blue_q  <= (a_in == b_in);
      valid_q <= 1'b1;
    end
  end

  assign bus.green = green_q;
  assign bus.red   = red_q;
  assign bus.blue  = blue_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_lab4.sv
// Scoreboard bench for lab4: stimulus queues expected {valid,green,red,blue}
// per cycle, a negedge monitor pops and compares.
module tb_lab4;

  localparam int unsigned WIDTH = 2;
  localparam logic [3:0] E0 = 4'b0000;
  localparam logic [3:0] EG = 4'b1100;
  localparam logic [3:0] ER = 4'b1010;
  localparam logic [3:0] EB = 4'b1001;

  typedef struct {
    int unsigned due;
    logic [3:0]  exp;
    string       name;
  } item_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned tests;
  int unsigned failed;
  item_t       sb[$];

  lab4_if #(.WIDTH(WIDTH)) bus ();

  lab4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  assert property (@(negedge clk) bus.valid |-> $onehot({bus.green, bus.red, bus.blue}));

  // Monitor: compare every queued expectation that has come due, plus the
  // one-hot invariant whenever valid is up.
  always @(negedge clk) begin
    item_t      it;
    logic [3:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it  = sb.pop_front();
      act = {bus.valid, bus.green, bus.red, bus.blue};
      tests = tests + 1;
      if (act !== it.exp) begin
        failed = failed + 1;
        $display("FAIL %s: got vgrb=%b expected %b", it.name, act, it.exp);
      end
    end
    if (bus.valid === 1'b1) begin
      tests = tests + 1;
      if (!$onehot({bus.green, bus.red, bus.blue})) begin
        failed = failed + 1;
        $display("FAIL onehot: got grb=%b expected exactly one bit set",
                 {bus.green, bus.red, bus.blue});
      end
    end
  end

  task automatic apply(input logic en, input int unsigned a, input int unsigned b,
                       input logic [3:0] exp, input string name);
    item_t it;
    @(posedge clk);
    #1;
    bus.en = en;
    bus.a  = a[WIDTH-1:0];
    bus.b  = b[WIDTH-1:0];
    it.due  = cyc + 1;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    bus.en = 1'b0;
    apply(1'b0, 0, 0, E0, "post_rst_idle0");
    apply(1'b0, 3, 1, E0, "post_rst_idle1");
    apply(1'b0, 1, 3, E0, "post_rst_idle2");
    apply(1'b1, 0, 0, EB, "post_rst_first_capture");
  endtask

  // Expected codes for the 16 pairs, index a*4+b, worked out by hand.
  logic [3:0] exh [16];

  initial begin
    logic [3:0] act;
    tests  = 0;
    failed = 0;
    exh = '{EB, ER, ER, ER,
            EG, EB, ER, ER,
            EG, EG, EB, ER,
            EG, EG, EG, EB};

    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.a  = '0;
    bus.b  = '0;

    // Held in reset: enable must not capture.
    apply(1'b1, 3, 0, E0, "in_reset0");
    apply(1'b1, 0, 3, E0, "in_reset1");
    release_reset();

    for (int i = 0; i < 16; i++) begin
      apply(1'b1, i / 4, i % 4, exh[i], $sformatf("exh a=%0d b=%0d", i / 4, i % 4));
    end

    apply(1'b1, 0, 2, ER, "hold_capture");
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 3, 0, ER, $sformatf("hold_%0d", i));
    end

    apply(1'b1, 1, 1, EB, "latency_eq");
    apply(1'b1, 2, 1, EG, "latency_gt");
    apply(1'b1, 3, 0, EG, "pre_reset_green");

    // Assert reset between edges while green is showing.
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    act = {bus.valid, bus.green, bus.red, bus.blue};
    tests = tests + 1;
    if (act !== E0) begin
      failed = failed + 1;
      $display("FAIL async_reset: got vgrb=%b expected %b", act, E0);
    end
    apply(1'b1, 2, 0, E0, "mid_reset_hold");
    release_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    tests = tests + 1;
    if (sb.size() != 0) begin
      failed = failed + 1;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lab4.md
LAB4 -- requirements
Module: lab4

Interface
REQ-001 Parameter WIDTH, default 2, sets the operand width in bits; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  compare-enable; operands are sampled only when high.
REQ-005 a  input  WIDTH  unsigned operand A.
REQ-006 b  input  WIDTH  unsigned operand B.
REQ-007 green  output  1  registered flag: A greater than B.
REQ-008 red  output  1  registered flag: A less than B.
REQ-009 blue  output  1  registered flag: A equal to B.
REQ-010 valid  output  1  high once at least one compare result has been captured since reset.

Function
REQ-011 The block SHALL compare a and b as unsigned integers of WIDTH bits.
REQ-012 On a rising clk edge with en=1, the block SHALL capture the result so that green=(a>b), red=(a<b) and blue=(a==b).
REQ-013 Latency SHALL be exactly one clock: results reflect a/b/en as sampled at the previous rising edge.
REQ-014 With en=0 at a rising edge, green/red/blue/valid SHALL hold their previous values regardless of a and b.
REQ-015 Whenever valid=1, exactly one of green, red and blue SHALL be 1 (one-hot).
REQ-016 valid SHALL go to 1 on the first rising edge with en=1 after reset and stay 1 until the next reset.
REQ-017 Outputs SHALL be driven directly from flops, with no combinational path from a, b or en to any output.
REQ-018 Boundary cases: a=b=0 gives blue; a=max, b=0 gives green; a=0, b=max gives red; a=b=max gives blue.
REQ-019 Operand changes between clock edges SHALL have no effect on the outputs until the next enabled edge.

Reset
REQ-020 While rst_n=0, green, red, blue and valid SHALL be 0, and they SHALL reach 0 immediately, without waiting for a clock edge.
REQ-021 Reset asserted mid-operation SHALL discard the held result; after deassertion the outputs SHALL stay 0 until the first enabled edge.
REQ-022 Reset deassertion SHALL be synchronised internally so that the first capture occurs no earlier than the second rising edge after rst_n rises; the bench SHALL not rely on the first edge.

Verification
REQ-023 Exhaustive check, WIDTH=2, en=1: apply all 16 (a,b) pairs, one per clock -> each next cycle shows the correct one-hot flag (e.g. a=2,b=1 -> green=1; a=1,b=3 -> red=1; a=3,b=3 -> blue=1).
REQ-024 Reset check: assert rst_n=0 between clock edges while green=1 -> all outputs 0 immediately, and valid=0.
REQ-025 Hold check: capture a=0,b=2 (red=1), then set en=0 and apply a=3,b=0 for 3 cycles -> red stays 1, green stays 0.
REQ-026 Latency check: change a=1,b=1 to a=2,b=1 at one edge -> blue=1 for that cycle, green=1 only after the next edge.
REQ-027 Post-reset check: release rst_n with en=0 -> valid=0 and all flags 0; raise en with a=0,b=0 -> blue=1 and valid=1 after capture.
REQ-028 Invariant check: on every cycle with valid=1, green+red+blue==1, asserted throughout all scenarios above.
